// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 serial SRAM responder (READ/WRITE, auto-increment)
// Optional mode register (RDMR/WRMR, byte mode) under SPI_RAM_RESPONDER_MODE_REG_EN.
module spi_ram_responder #(
    parameter int         ADDR_BITS = 10,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic active
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, IGNORE} state_t;

    state_t               state;
    logic [2:0]           sclk_q;
    logic [1:0]           cs_q;
    logic [1:0]           mosi_q;
    logic                 armed;
    logic [2:0]           bit_cnt;
    logic [1:0]           byte_cnt;
    logic [6:0]           sr;
    logic [7:0]           tx;
    logic                 is_read;
    logic                 reload;
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           mem [DEPTH];

    logic                 rise, fall, cs_s, mosi_s;
    logic [7:0]           sr_next;
    logic [ADDR_BITS-1:0] addr_next;
    logic                 wr_byte_done, mem_we;

`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
    logic [7:0] mode;
    logic       mode_op;
    logic       last_byte;
    logic       seq_mode;
    assign seq_mode = (mode[7:6] != 2'b00);
`endif

    // Sync stages are plain data pipes; only the FSM state is reset.
    always_ff @(posedge clk) begin
        sclk_q <= {sclk_q[1:0], spi_clk};
        cs_q   <= {cs_q[0], spi_cs_n};
        mosi_q <= {mosi_q[0], spi_mosi};
    end

    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign cs_s      = cs_q[1];
    assign mosi_s    = mosi_q[1];
    assign sr_next   = {sr, mosi_s};
    assign addr_next = {addr[ADDR_BITS-2:0], mosi_s};

    assign wr_byte_done = (state == WR) && !cs_s && rise && (bit_cnt == 3'd7);
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
    assign mem_we = wr_byte_done && !mode_op;
`else
    assign mem_we = wr_byte_done;
`endif

    always_ff @(posedge clk) begin
        if (!reset && mem_we)
            mem[addr] <= sr_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            active      <= 1'b0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 2'd0;
            armed       <= 1'b0;
            reload      <= 1'b0;
            is_read     <= 1'b0;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
            mode        <= 8'h40;
            mode_op     <= 1'b0;
            last_byte   <= 1'b0;
`endif
        end else if (cs_s) begin
            // Deselect wins over any same-cycle clock edge; armed re-enables IDLE after a reset.
            state       <= IDLE;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            active      <= 1'b0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 2'd0;
            reload      <= 1'b0;
            armed       <= 1'b1;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
            mode_op     <= 1'b0;
            last_byte   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (armed) begin
                        state    <= CMD;
                        active   <= 1'b1;
                        bit_cnt  <= 3'd0;
                        byte_cnt <= 2'd0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        sr      <= sr_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (sr_next == CMD_READ || sr_next == CMD_WRITE) begin
                                state   <= ADDR;
                                is_read <= (sr_next == CMD_READ);
                            end
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                            else if (sr_next == 8'h05) begin
                                state       <= RD;
                                tx          <= mode;
                                mode_op     <= 1'b1;
                                spi_miso_oe <= 1'b1;
                            end else if (sr_next == 8'h01) begin
                                state   <= WR;
                                mode_op <= 1'b1;
                            end
`endif
                            else
                                state <= IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (rise) begin
                        addr    <= addr_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd2) begin
                                if (is_read) begin
                                    tx          <= mem[addr_next];
                                    state       <= RD;
                                    spi_miso_oe <= 1'b1;
                                end else begin
                                    state <= WR;
                                end
                            end
                        end
                    end
                end
                RD: begin
                    // Reload happens the cycle after the 8th fall, well before the next fall.
                    if (reload) begin
                        reload <= 1'b0;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                        tx <= mode_op ? mode : mem[addr];
`else
                        tx <= mem[addr];
`endif
                    end else if (fall) begin
                        spi_miso <= tx[7];
                        tx       <= {tx[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            reload <= 1'b1;
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                            if (!mode_op) addr <= addr + 1'b1;
                            if (!mode_op && !seq_mode) last_byte <= 1'b1;
`else
                            addr <= addr + 1'b1;
`endif
                        end
                    end
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                    // Byte mode: hold bit0 until the master has sampled it, then go quiet.
                    else if (rise && last_byte) begin
                        state       <= IGNORE;
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                    end
`endif
                end
                WR: begin
                    if (rise) begin
                        sr      <= sr_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
                            if (mode_op) begin
                                mode  <= sr_next;
                                state <= IGNORE;
                            end else begin
                                addr <= addr + 1'b1;
                                if (!seq_mode) state <= IGNORE;
                            end
`else
                            addr <= addr + 1'b1;
`endif
                        end
                    end
                end
                IGNORE: begin
                    spi_miso    <= 1'b0;
                    spi_miso_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - self-checking bench for spi_ram_responder against a byte-array model
module tb_spi_ram_responder;
    logic clk = 1'b0;
    logic reset, spi_clk, spi_cs_n, spi_mosi;
    logic spi_miso, spi_miso_oe, active;

    always #5 clk = ~clk;

    spi_ram_responder dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .active(active)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] ref_mem [1024];
    logic [7:0] rx_b, oe_b, rx_or, oe_or;
    logic [7:0] q [$];
    int rec_a [$];
    int rec_n [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode-0 bit: drive MOSI in the low phase, sample MISO just before the rising edge.
    task automatic spi_bits(input logic [7:0] dout, input int n);
        rx_b = 8'h00;
        oe_b = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = dout[i];
            tick(4);
            rx_b[i] = spi_miso;
            oe_b[i] = spi_miso_oe;
            spi_clk = 1'b1;
            tick(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        tick(2);
    endtask

    task automatic cs_end();
        tick(4);
        spi_cs_n = 1'b1;
        tick(6);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        oe_or = 8'h00;
        send(op);          oe_or |= oe_b;
        send(a[23:16]);    oe_or |= oe_b;
        send(a[15:8]);     oe_or |= oe_b;
        send(a[7:0]);      oe_or |= oe_b;
    endtask

    task automatic do_write(input logic [23:0] a, input logic [7:0] d [$]);
        cs_begin();
        send_hdr(8'h02, a);
        foreach (d[i]) send(d[i]);
        cs_end();
        foreach (d[i]) ref_mem[(int'(a[9:0]) + i) % 1024] = d[i];
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input string tag);
        cs_begin();
        send_hdr(8'h03, a);
        check({tag, "_hdr_oe"}, oe_or, 8'h00);
        for (int i = 0; i < n; i++) begin
            send(8'($urandom));
            check({tag, "_data"}, rx_b, ref_mem[(int'(a[9:0]) + i) % 1024]);
            check({tag, "_oe"}, oe_b, 8'hFF);
        end
        check({tag, "_active"}, active, 1'b1);
        cs_end();
        check({tag, "_oe_after"}, spi_miso_oe, 1'b0);
        check({tag, "_active_after"}, active, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int a, n, k;
        reset = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        tick(5);
        check("reset_miso", spi_miso, 1'b0);
        check("reset_oe", spi_miso_oe, 1'b0);
        check("reset_active", active, 1'b0);
        reset = 1'b0;
        tick(4);

        // 1: single-byte write/read
        do_write(24'h000010, '{8'hA5});
        do_read(24'h000010, 1, "t1");

        // 2: wrap-around at the top of memory, upper address bits ignored
        q = '{8'h11, 8'h22, 8'h33};
        do_write(24'hAB03FF, q);
        check("t2_model_wrap", ref_mem[0], 8'h22);
        do_read(24'h0003FF, 3, "t2");
        do_read(24'h000000, 2, "t2_low");

        // 3: partial byte discarded on deselect
        v = 8'($urandom);
        do_write(24'h000021, '{v});
        cs_begin();
        send_hdr(8'h02, 24'h000020);
        send(8'hC3);
        spi_bits(8'h5A, 4);
        cs_end();
        ref_mem[8'h20] = 8'hC3;
        do_read(24'h000020, 2, "t3");

        // 4: unknown opcode stays silent
        cs_begin();
        send(8'h9F);
        rx_or = 8'h00; oe_or = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom));
            rx_or |= rx_b; oe_or |= oe_b;
        end
        check("t4_active", active, 1'b1);
        cs_end();
        check("t4_miso", rx_or, 8'h00);
        check("t4_oe", oe_or, 8'h00);
        do_read(24'h000010, 1, "t4_rd");
        do_read(24'h0003FF, 3, "t4_rd_wrap");

        // 5: reset in the read data phase
        v = 8'($urandom);
        do_write(24'h000040, '{v});
        cs_begin();
        send_hdr(8'h03, 24'h000040);
        spi_bits(8'h00, 3);
        check("t5_oe_before", spi_miso_oe, 1'b1);
        reset = 1'b1;
        tick(1);
        check("t5_miso", spi_miso, 1'b0);
        check("t5_oe", spi_miso_oe, 1'b0);
        check("t5_active", active, 1'b0);
        reset = 1'b0;
        spi_bits(8'h00, 8);
        check("t5_stay_idle", active, 1'b0);
        check("t5_stay_oe", spi_miso_oe, 1'b0);
        cs_end();
        do_read(24'h000040, 1, "t5_rd");

`ifdef SPI_RAM_RESPONDER_MODE_REG_EN
        // 6: mode register and byte mode
        v = 8'($urandom);
        do_write(24'h000051, '{v});
        cs_begin();
        send(8'h05);
        send(8'h00); check("t6_rdmr0", rx_b, 8'h40);
        send(8'h00); check("t6_rdmr1", rx_b, 8'h40);
        cs_end();
        cs_begin(); send(8'h01); send(8'h00); cs_end();
        cs_begin();
        send_hdr(8'h02, 24'h000050);
        send(8'h77); send(8'h88);
        cs_end();
        ref_mem[8'h50] = 8'h77;
        cs_begin(); send(8'h01); send(8'h40); cs_end();
        cs_begin(); send(8'h05); send(8'h00); check("t6_rdmr_restore", rx_b, 8'h40); cs_end();
        do_read(24'h000050, 2, "t6_rd");
`else
        cs_begin();
        send(8'h05);
        rx_or = 8'h00; oe_or = 8'h00;
        send(8'h00); rx_or |= rx_b; oe_or |= oe_b;
        send(8'h00); rx_or |= rx_b; oe_or |= oe_b;
        cs_end();
        check("t6_rdmr_ignored_miso", rx_or, 8'h00);
        check("t6_rdmr_ignored_oe", oe_or, 8'h00);
`endif

        // Random writes, each followed by a read-back of some earlier write
        for (int it = 0; it < 12; it++) begin
            a = int'($urandom_range(0, 1023));
            n = int'($urandom_range(1, 4));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_write({8'($urandom), 6'($urandom), a[9:0]}, q);
            rec_a.push_back(a);
            rec_n.push_back(n);
            k = int'($urandom_range(0, rec_a.size() - 1));
            do_read({8'($urandom), 6'($urandom), rec_a[k][9:0]}, rec_n[k], "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
